// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR bank command arbiter.
// Holds the FSM state encoding, default sizing and a clog2 helper used to
// derive index and counter widths.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPulse  = 2'd1,
    StSettle = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned DefNreq   = 4;
  localparam int unsigned DefNbits  = 8;
  localparam int unsigned DefPulseW = 1;
  localparam int unsigned DefSettle = 2;

  // Minimum result is 1 so that derived vectors are never zero-width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < 32; b++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter_nreq.sv
// Combinational round-robin arbiter.
// Ports:
//   req    - request vector, one bit per requester
//   rr_ptr - highest-priority requester index for this decision
//   gnt    - one-hot grant (all zero when no request)
//   gnt_id - binary index of the granted requester
//   any_req- at least one request is pending
module rr_arbiter_nreq #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any_req
);

  logic [IDW-1:0] cand;
  logic           found;

  // Walk upward from rr_ptr, wrapping modulo NREQ; first hit wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        gnt[cand]   = 1'b1;
        gnt_id      = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/sr_cmd_arbiter.sv
// Shares one bank of gated SR cells between NREQ requesters.
// Grants set/clear commands round-robin, drives one exclusive S or R strobe
// for PULSE_W cycles, waits SETTLE idle cycles, then acks for one cycle and
// updates a shadow copy of the bank.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   req_valid   - per-requester request pending
//   req_set     - per-requester op: 1 = set, 0 = clear
//   req_idx     - per-requester target bit, IDXW bits each
//   req_ack     - one-hot one-cycle completion pulse
//   s_out/r_out - set/reset strobes to the bank
//   shadow_q    - controller's view of the bank
//   busy        - high whenever the FSM is not idle
//   err         - pulses with req_ack when the index was out of range
module sr_cmd_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned NREQ    = DefNreq,
  parameter int unsigned NBITS   = DefNbits,
  parameter int unsigned IDXW    = clog2(DefNbits),
  parameter int unsigned PULSE_W = DefPulseW,
  parameter int unsigned SETTLE  = DefSettle
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_set,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      req_ack,
  output logic [NBITS-1:0]     s_out,
  output logic [NBITS-1:0]     r_out,
  output logic [NBITS-1:0]     shadow_q,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned IDW    = clog2(NREQ);
  localparam int unsigned CntMax = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
  localparam int unsigned CNTW   = clog2(CntMax + 1);

  state_e            state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [CNTW-1:0]   cnt_q;
  logic [IDW-1:0]    gnt_id_q;
  logic              op_set_q;
  logic [NBITS-1:0]  mask_q;
  logic              oor_q;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_id;
  logic              any_req;

  logic [IDXW-1:0]   sel_idx;
  logic              sel_set;
  logic              sel_in_range;
  logic [NBITS-1:0]  sel_mask;

  logic [NREQ-1:0]   ack_vec;
  logic [IDW-1:0]    ptr_next;
  logic [NBITS-1:0]  shadow_next;

  rr_arbiter_nreq #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_req (any_req)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_idx = req_idx[i*IDXW +: IDXW];
    end
  end

  assign sel_set      = |(req_set & gnt);
  assign sel_in_range = (32'(sel_idx) < NBITS);
  // Out-of-range commands carry an empty mask: no strobe, no shadow change.
  assign sel_mask     = sel_in_range ? (NBITS'(1) << sel_idx) : '0;

  assign ack_vec     = NREQ'(1) << gnt_id_q;
  assign ptr_next    = IDW'((32'(gnt_id_q) + 32'd1) % NREQ);
  assign shadow_next = op_set_q ? (shadow_q | mask_q) : (shadow_q & ~mask_q);

  // Completion side effects are registered on the edge entering StDone so
  // req_ack/err are high exactly for the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      gnt_id_q <= '0;
      op_set_q <= 1'b0;
      mask_q   <= '0;
      oor_q    <= 1'b0;
      s_out    <= '0;
      r_out    <= '0;
      req_ack  <= '0;
      shadow_q <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      req_ack <= '0;
      err     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_id_q <= gnt_id;
            op_set_q <= sel_set;
            mask_q   <= sel_mask;
            oor_q    <= !sel_in_range;
            s_out    <= sel_set ? sel_mask : '0;
            r_out    <= sel_set ? '0 : sel_mask;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StPulse;
          end
        end
        StPulse: begin
          if (cnt_q == CNTW'(PULSE_W - 1)) begin
            s_out <= '0;
            r_out <= '0;
            cnt_q <= '0;
            if (SETTLE == 0) begin
              state_q  <= StDone;
              req_ack  <= ack_vec;
              err      <= oor_q;
              shadow_q <= shadow_next;
              rr_ptr_q <= ptr_next;
            end else begin
              state_q <= StSettle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSettle: begin
          if (cnt_q == CNTW'(SETTLE - 1)) begin
            cnt_q    <= '0;
            state_q  <= StDone;
            req_ack  <= ack_vec;
            err      <= oor_q;
            shadow_q <= shadow_next;
            rr_ptr_q <= ptr_next;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bank safety invariants.
  a_sr_excl: assert property (@(posedge clk) disable iff (!rst_n) (s_out & r_out) == '0);
  a_strobe_1h: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(s_out | r_out));
  a_ack_1h: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ack));
  a_strobe_pulse: assert property (@(posedge clk) disable iff (!rst_n)
                                   ((s_out | r_out) != '0) |-> (state_q == StPulse));

endmodule

// File: doc/sr_cmd_arbiter.md
Name: sr_cmd_arbiter

Overview:
Shares one bank of NBITS gated SR storage cells (sr_flipflop instances) between NREQ requesters. Each requester asks to set or clear one bit of the bank. The block grants requests round-robin and drives a single exclusive S or R strobe per command, then allows a settle window before acknowledging. It guarantees that S and R for any cell are never high together, and it keeps a shadow copy of the bank contents.

Parameters:
NREQ, 4, number of requesters
NBITS, 8, number of SR cells in the bank
IDXW, 3, width of a bit index, ceil(log2(NBITS))
PULSE_W, 1, number of cycles the S/R strobe is held high (1 or more)
SETTLE, 2, number of idle cycles after the strobe before the ack (0 or more)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
req_valid  in  NREQ  request pending, one bit per requester
req_set  in  NREQ  per-requester operation: 1 = set, 0 = clear
req_idx  in  NREQ*IDXW  per-requester target bit; requester i uses bits [i*IDXW +: IDXW]
req_ack  out  NREQ  one-hot, one-cycle completion pulse
s_out  out  NBITS  set strobes to the bank
r_out  out  NBITS  reset strobes to the bank
shadow_q  out  NBITS  controller's view of the bank contents
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse when a command with an out-of-range index completes

Behaviour:
- Reset: rst_n=0 sampled at a clk edge forces the following, regardless of state:
  - state=IDLE, rr_ptr=0
  - s_out, r_out, req_ack, shadow_q, busy and err all 0
  - A reset in the middle of a command aborts it. Any strobe drops at that edge and no ack is issued.
- States: IDLE, PULSE, SETTLE, DONE.
- IDLE:
  - If any req_valid is high, the winner is the first valid requester searching upward from rr_ptr, modulo NREQ.
  - The grant latches gnt_id, req_set[gnt_id] and req_idx[gnt_id], and moves to PULSE.
  - With no valid request, stay in IDLE.
- PULSE:
  - Lasts PULSE_W cycles.
  - Drives s_out[idx]=1 if the latched op is set, otherwise r_out[idx]=1. All other strobe bits are 0.
  - Strobes are registered outputs.
  - Moves to SETTLE, or to DONE if SETTLE=0.
- SETTLE: lasts SETTLE cycles with all strobes 0, then moves to DONE.
- DONE: lasts 1 cycle.
  - req_ack[gnt_id]=1.
  - shadow_q[idx] is updated at this edge to 1 for set, 0 for clear.
  - rr_ptr = (gnt_id+1) mod NREQ.
  - Moves to IDLE.
- Timing, with a grant sampled at edge E0:
  - Strobe is high for cycles E0..E(PULSE_W).
  - req_ack is high during the cycle after edge E(PULSE_W+SETTLE).
  - A new grant is possible at edge E(PULSE_W+SETTLE+2).
  - Command period is PULSE_W+SETTLE+2 cycles (5 at the defaults).
- Handshake:
  - A requester holds req_valid until it sees its req_ack. It must drop or change req_valid in the cycle its ack is high, or it is granted again.
  - If req_valid drops before a grant, the request is lost with no ack.
  - Changes to req_valid, req_set or req_idx after the grant are ignored. The latched command completes and is acked.
- Out-of-range index (idx ≥ NBITS):
  - No strobe is driven and shadow_q is unchanged.
  - The full timing sequence still runs.
  - err pulses together with req_ack.
- Invariants, checked by assertions:
  - (s_out & r_out)==0 always.
  - popcount(s_out|r_out) ≤ 1.
  - popcount(req_ack) ≤ 1.
  - Strobes are only nonzero in PULSE.
- Redundant commands, such as setting a bit that is already set, are issued normally so that latency stays fixed.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,… and each requester waits at most NREQ command periods.

Decomposition:
- Shared package sr_ctrl_pkg holds:
  - the state encoding localparams (IDLE=2'd0, PULSE=2'd1, SETTLE=2'd2, DONE=2'd3)
  - the default widths
  - a clog2 function for deriving IDXW
- One sub-module: rr_arbiter_nreq, combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, binary gnt_id, any_req.
- Counters and the FSM stay in the top module.

Test Plan (defaults):
1. Reset, then requester 2 asks to set idx 5 → edge E0 grant; s_out=8'h20 for one cycle; r_out=0 throughout; req_ack=4'b0100 during the cycle after edge E3; shadow_q=8'h20 afterwards.
2. All four requesters valid and holding, with requester i asking to clear idx i → acks come in order 0,1,2,3, each 5 cycles apart; only r_out strobes appear; bits 0..3 of shadow_q are cleared.
3. Requester 1 sets idx 3 while requester 3 clears idx 3 in the same cycle, with rr_ptr=0 → requester 1 is served first (s_out=8'h08), then requester 3 (r_out=8'h08); s_out & r_out is never nonzero; final shadow_q bit 3 is 0.
4. rst_n pulled low during the SETTLE of a set to idx 7 → at the next edge all outputs are 0 and rr_ptr=0; no req_ack for the aborted command; after release, the first grant starts from requester 0.
5. Requester 0 asks with idx value 9 on an override with IDXW=4, NBITS=8 → no strobe; err and req_ack[0] pulse together at the DONE cycle; shadow_q is unchanged.
6. Requester 1 drops req_valid before it is granted while requester 0 is being served → requester 1 gets no ack; the FSM returns to IDLE and busy=0.
